// File: rtl/bus_drvr_fifo.sv
// bus_drvr_fifo: per-node driver-side buffer for one slot of the parallel bus.
//
// An outbound FIFO takes local packets over in_valid/in_ready and presents them
// to the arbiter as pndng/pop/D_pop. The read side is show-ahead. An inbound
// FIFO captures bus deliveries from push/D_push and hands them to the local node
// over out_valid/out_ready. push has no backpressure. A delivery into a full
// inbound FIFO is dropped and sets the sticky rx_ovf flag.
//
// Optional build macro DRVR_ADDR_FILTER_EN: when it is defined, an inbound
// packet whose destination ID (D_push[bits-1 -: 8]) is neither my_id nor
// broadcast is discarded, and the sticky rx_misaddr flag is set. When it is not
// defined, rx_misaddr is tied to 0.
//
// Ports:
//   clk, reset            single clock; synchronous active-low reset
//   in_valid/in_ready     local packet in (in_data)
//   pndng/pop/D_pop       outbound head to the arbiter
//   push/D_push           bus delivery in
//   out_valid/out_ready   inbound head to the local node (out_data)
//   tx_level, rx_level    FIFO occupancy, 0..depth
//   rx_ovf, rx_misaddr    sticky error flags
module bus_drvr_fifo #(
  parameter int unsigned bits      = 256,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  my_id     = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [bits-1:0]          in_data,
  output logic                     pndng,
  input  logic                     pop,
  output logic [bits-1:0]          D_pop,
  input  logic                     push,
  input  logic [bits-1:0]          D_push,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [bits-1:0]          out_data,
  output logic [$clog2(depth):0]   tx_level,
  output logic [$clog2(depth):0]   rx_level,
  output logic                     rx_ovf,
  output logic                     rx_misaddr
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(depth);

  logic [bits-1:0] tx_mem_q [depth];
  logic [bits-1:0] rx_mem_q [depth];

  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [LW-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic          rx_ovf_q, rx_ovf_d;

  logic tx_wr, tx_rd, rx_wr, rx_rd, rx_full;
  logic addr_hit, addr_ok;

  // ---------------- outbound ----------------
  // in_ready is forced low while reset is held so nothing lands during a reset.
  assign in_ready = reset & (tx_level_q != FULL);
  assign pndng    = (tx_level_q != '0);
  assign D_pop    = pndng ? tx_mem_q[tx_rd_ptr_q] : '0;

  assign tx_wr = in_valid & in_ready;
  assign tx_rd = pop & pndng;

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q + AW'(tx_wr);
    tx_rd_ptr_d = tx_rd_ptr_q + AW'(tx_rd);
    tx_level_d  = tx_level_q + LW'(tx_wr) - LW'(tx_rd);
  end

  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem_q[tx_wr_ptr_q] <= in_data;
  end

  // ---------------- inbound ----------------
  assign out_valid = (rx_level_q != '0);
  assign out_data  = out_valid ? rx_mem_q[rx_rd_ptr_q] : '0;

  assign addr_hit = (D_push[bits-1 -: 8] == my_id) ||
                    (D_push[bits-1 -: 8] == broadcast);

`ifdef DRVR_ADDR_FILTER_EN
  assign addr_ok = addr_hit;

  logic rx_misaddr_q, rx_misaddr_d;
  assign rx_misaddr_d = rx_misaddr_q | (push & ~addr_ok);

  always_ff @(posedge clk) begin
    if (!reset) rx_misaddr_q <= 1'b0;
    else        rx_misaddr_q <= rx_misaddr_d;
  end
  assign rx_misaddr = rx_misaddr_q;
`else
  // No filtering: every push counts as addressed. The match is still
  // referenced so the ID parameters stay meaningful in both builds.
  assign addr_ok    = addr_hit | 1'b1;
  assign rx_misaddr = 1'b0;
`endif

  assign rx_rd   = out_valid & out_ready;
  assign rx_full = (rx_level_q == FULL);
  // A read in the same cycle frees the slot, so a push into a full FIFO still
  // lands in that case.
  assign rx_wr   = reset & push & addr_ok & (~rx_full | rx_rd);

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q + AW'(rx_wr);
    rx_rd_ptr_d = rx_rd_ptr_q + AW'(rx_rd);
    rx_level_d  = rx_level_q + LW'(rx_wr) - LW'(rx_rd);
    rx_ovf_d    = rx_ovf_q | (push & addr_ok & rx_full & ~rx_rd);
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem_q[rx_wr_ptr_q] <= D_push;
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_level_q  <= '0;
      rx_ovf_q    <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_level_q  <= tx_level_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_level_q  <= rx_level_d;
      rx_ovf_q    <= rx_ovf_d;
    end
  end

  assign tx_level = tx_level_q;
  assign rx_level = rx_level_q;
  assign rx_ovf   = rx_ovf_q;

endmodule
